// File: rtl/hit_counter_bank_pkg.sv
// Shared types and sizing helpers for the hit counter bank.
package hit_counter_bank_pkg;

   localparam int MAX_NCH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   // Index field must hold NCH itself, the slot of the summary channel.
   function automatic int idx_width(input int nch);
      return (nch < 1) ? 1 : $clog2(nch + 1);
   endfunction

endpackage

// File: rtl/hit_counter_channel.sv
// One saturating hit counter with sticky overflow and a snapshot register; load swaps live into snapshot.
// Latency: count visible the cycle after inc; no backpressure (counts every cycle).
module hit_counter_channel #(
   parameter int CW = 16
) (
   input  logic          clk40,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          load,
   output logic [CW-1:0] cnt,
   output logic          ovf,
   output logic [CW-1:0] snap_cnt,
   output logic          snap_ovf
);

   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         ovf      <= 1'b0;
         snap_cnt <= '0;
         snap_ovf <= 1'b0;
      end else if (load) begin
         // A hit in the load cycle opens the next frame, so nothing is lost or double-counted.
         snap_cnt <= cnt;
         snap_ovf <= ovf;
         cnt      <= inc ? CW'(1) : '0;
         ovf      <= 1'b0;
      end else if (inc) begin
         // Overflow marks a hit dropped at full scale.
         if (&cnt) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/hit_counter_bank.sv
// Bank of NCH hit counters plus optional any-hit channel; start snapshots+clears, then streams one word per channel (HIT_COUNTER_BANK_PARITY_EN adds rd_parity).
// Latency: first rd_valid 2 cycles after start; words held stable while rd_ready=0, valid never drops without a transfer.
module hit_counter_bank
   import hit_counter_bank_pkg::*;
#(
   parameter  int NCH    = 9,
   parameter  int CW     = 16,
   parameter  int SUM_EN = 1,
   localparam int NW     = NCH + SUM_EN,
   localparam int IDXW   = idx_width(NCH),
   localparam int DW     = IDXW + 1 + CW
) (
   input  logic           clk40,
   input  logic           rst_n,
   input  logic [NCH-1:0] hit,
   input  logic           start,
   output logic           busy,
   output logic [DW-1:0]  rd_data,
   output logic           rd_valid,
   input  logic           rd_ready,
   output logic           rd_last
`ifdef HIT_COUNTER_BANK_PARITY_EN
   ,
   output logic           rd_parity
`endif
);

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic            load;
   logic            xfer;

   logic [CW-1:0]   live_cnt [NW];
   logic [CW-1:0]   snap_cnt [NW];
   logic [NW-1:0]   live_ovf;
   logic [NW-1:0]   snap_ovf;

   logic [IDXW-1:0] nxt_idx;
   logic [CW-1:0]   nxt_cnt;
   logic            nxt_ovf;
   logic            nxt_last;
   logic [DW-1:0]   nxt_word;

   assign load = (state == LOAD);
   assign xfer = rd_valid && rd_ready;

   generate
      if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
         $error("hit_counter_bank: NCH out of range");
      end

      for (genvar i = 0; i < NCH; i++) begin : g_ch
         hit_counter_channel #(.CW(CW)) u_ch (
            .clk40    (clk40),
            .rst_n    (rst_n),
            .inc      (hit[i]),
            .load     (load),
            .cnt      (live_cnt[i]),
            .ovf      (live_ovf[i]),
            .snap_cnt (snap_cnt[i]),
            .snap_ovf (snap_ovf[i])
         );
      end

      if (SUM_EN != 0) begin : g_sum
         hit_counter_channel #(.CW(CW)) u_sum (
            .clk40    (clk40),
            .rst_n    (rst_n),
            .inc      (|hit),
            .load     (load),
            .cnt      (live_cnt[NCH]),
            .ovf      (live_ovf[NCH]),
            .snap_cnt (snap_cnt[NCH]),
            .snap_ovf (snap_ovf[NCH])
         );
      end
   endgenerate

   // Word 0 is registered in the LOAD cycle straight from the live counters, which
   // hold exactly the value the snapshot captures on that same edge.
   always_comb begin
      nxt_idx = load ? '0 : ptr + IDXW'(1);
      nxt_cnt = '0;
      nxt_ovf = 1'b0;
      for (int k = 0; k < NW; k++) begin
         if (nxt_idx == IDXW'(k)) begin
            nxt_cnt = load ? live_cnt[k] : snap_cnt[k];
            nxt_ovf = load ? live_ovf[k] : snap_ovf[k];
         end
      end
      nxt_last = (nxt_idx == IDXW'(NW - 1));
      nxt_word = {nxt_idx, nxt_ovf, nxt_cnt};
   end

   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         busy      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
`ifdef HIT_COUNTER_BANK_PARITY_EN
         rd_parity <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               state     <= SEND;
               ptr       <= '0;
               rd_valid  <= 1'b1;
               rd_data   <= nxt_word;
               rd_last   <= nxt_last;
`ifdef HIT_COUNTER_BANK_PARITY_EN
               rd_parity <= ^nxt_word;
`endif
            end
            SEND: begin
               if (xfer) begin
                  if (rd_last) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                  end else begin
                     ptr       <= nxt_idx;
                     rd_data   <= nxt_word;
                     rd_last   <= nxt_last;
`ifdef HIT_COUNTER_BANK_PARITY_EN
                     rd_parity <= ^nxt_word;
`endif
                  end
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hit_counter_bank.sv
// Directed bench for hit_counter_bank (NCH=9, CW=4, SUM_EN=1) with a spec-level counter model and word scoreboard.
module tb_hit_counter_bank;

   localparam int NCH  = 9;
   localparam int CW   = 4;
   localparam int NW   = 10;
   localparam int IDXW = 4;
   localparam int DW   = 9;

   typedef struct {
      logic [DW-1:0] w;
      logic          last;
   } exp_t;

   logic           clk40 = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] hit;
   logic           start;
   logic           busy;
   logic [DW-1:0]  rd_data;
   logic           rd_valid;
   logic           rd_ready;
   logic           rd_last;
`ifdef HIT_COUNTER_BANK_PARITY_EN
   logic           rd_parity;
`endif

   int tests = 0;
   int fails = 0;

   exp_t          sb [$];
   logic [CW-1:0] m_cnt [NW];
   logic [NW-1:0] m_ovf;
   int            m_st;          // 0 idle, 1 load, 2 send
   logic          held;
   logic [DW-1:0] held_dat;
   logic [DW-1:0] got [NW];
   int            nx;

   always #5 clk40 = ~clk40;

   hit_counter_bank #(.NCH(NCH), .CW(CW), .SUM_EN(1)) dut (
      .clk40    (clk40),
      .rst_n    (rst_n),
      .hit      (hit),
      .start    (start),
      .busy     (busy),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_last  (rd_last)
`ifdef HIT_COUNTER_BANK_PARITY_EN
      ,
      .rd_parity(rd_parity)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      sb.delete();
      for (int k = 0; k < NW; k++) m_cnt[k] = '0;
      m_ovf = '0;
      m_st  = 0;
      held  = 1'b0;
      nx    = 0;
   endtask

   // One cycle: drive inputs at a negedge, check outputs, advance the model across the coming posedge.
   task automatic tick(input logic [NCH-1:0] h, input logic s, input logic rdy);
      logic [NW-1:0] incv;
      exp_t          e;
      int            nst;
      hit = h; start = s; rd_ready = rdy;
      nst = m_st;
      chk("busy", busy, m_st != 0);
      chk("rd_valid", rd_valid, m_st == 2);
      if (held) chk("hold_data", rd_data, held_dat);
      held     = rd_valid && !rdy;
      held_dat = rd_data;
      if (rd_valid && rdy) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rd_data", rd_data, e.w);
            chk("rd_last", rd_last, e.last);
`ifdef HIT_COUNTER_BANK_PARITY_EN
            chk("rd_parity", rd_parity, ^e.w);
`endif
            if (nx < NW) got[nx] = rd_data;
            nx++;
            if (e.last) nst = 0;
         end
      end
      incv = {|h, h};
      if (m_st == 1) begin
         for (int k = 0; k < NW; k++) begin
            e.w    = {4'(k), m_ovf[k], m_cnt[k]};
            e.last = (k == NW - 1);
            sb.push_back(e);
         end
         for (int k = 0; k < NW; k++) begin
            m_cnt[k] = incv[k] ? 4'd1 : 4'd0;
            m_ovf[k] = 1'b0;
         end
         nst = 2;
         nx  = 0;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (incv[k]) begin
               if (m_cnt[k] == 4'hF) m_ovf[k] = 1'b1;
               else m_cnt[k] = m_cnt[k] + 4'd1;
            end
         end
      end
      if (m_st == 0 && s) nst = 1;
      m_st = nst;
      @(negedge clk40);
   endtask

   // mode bit0: random hits, bit1: ready 0,0,1 with start pulses, bit2: random ready
   task automatic drain(input int mode);
      int             c;
      logic [NCH-1:0] h;
      logic           r;
      logic           s;
      c = 0;
      while (m_st != 0 && c < 300) begin
         h = mode[0] ? (9'($urandom) & 9'($urandom) & 9'($urandom)) : '0;
         if (mode[1])      r = (c % 3 == 2);
         else if (mode[2]) r = 1'($urandom_range(0, 1));
         else              r = 1'b1;
         s = mode[1] && (c % 4 == 1);
         tick(h, s, r);
         c++;
      end
      chk("frame_end", m_st, 0);
   endtask

   initial begin
      logic [DW-1:0] w;
      rst_n = 1'b0; hit = '0; start = 1'b0; rd_ready = 1'b0;
      model_clear();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_last", rd_last, 0);
      chk("rst_data", rd_data, 0);
      @(negedge clk40);
      @(negedge clk40);
      rst_n = 1'b1;

      // reset in the middle of a frame
      tick(9'h008, 0, 1);
      tick(9'h008, 0, 1);
      tick('0, 1, 1);
      tick('0, 0, 1);
      tick('0, 0, 1);
      tick('0, 0, 1);
      tick('0, 0, 1);
      rd_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rd_valid, 0);
      chk("midrst_data", rd_data, 0);
      model_clear();
      @(negedge clk40);
      @(negedge clk40);
      rst_n = 1'b1;
      tick('0, 1, 1);
      drain(0);
      chk("postrst_first", got[0], 0);
      w = {4'd3, 1'b0, 4'd0};
      chk("postrst_idx3", got[3], w);

      // basic counting, summary channel
      for (int i = 0; i < 5; i++) tick(9'h004, 0, 1);
      for (int i = 0; i < 3; i++) tick(9'h104, 0, 1);
      tick('0, 1, 1);
      drain(0);
      chk("basic_words", nx, NW);
      w = {4'd2, 1'b0, 4'd8}; chk("basic_idx2", got[2], w);
      w = {4'd8, 1'b0, 4'd3}; chk("basic_idx8", got[8], w);
      w = {4'd9, 1'b0, 4'd8}; chk("basic_sum", got[9], w);
      w = {4'd0, 1'b0, 4'd0}; chk("basic_idx0", got[0], w);

      // saturation and sticky overflow, cleared by the next frame
      for (int i = 0; i < 20; i++) tick(9'h001, 0, 1);
      tick('0, 1, 1);
      drain(0);
      w = {4'd0, 1'b1, 4'd15}; chk("sat_idx0", got[0], w);
      w = {4'd9, 1'b1, 4'd15}; chk("sat_sum", got[9], w);
      tick('0, 1, 1);
      drain(0);
      w = {4'd0, 1'b0, 4'd0}; chk("sat_cleared", got[0], w);

      // backpressure with ignored start pulses
      tick(9'h0aa, 0, 1);
      tick('0, 1, 0);
      drain(2);
      chk("bp_xfers", nx, NW);
      w = {4'd1, 1'b0, 4'd1}; chk("bp_idx1", got[1], w);

      // snapshot boundary: start-cycle hit in this frame, load-cycle hit in the next
      tick(9'h002, 1, 1);
      tick(9'h002, 0, 1);
      drain(0);
      w = {4'd1, 1'b0, 4'd1}; chk("bnd_cur", got[1], w);
      tick('0, 1, 1);
      drain(0);
      w = {4'd1, 1'b0, 4'd1}; chk("bnd_next", got[1], w);

      // random hits and random ready across three frames
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 12; i++) tick(9'($urandom) & 9'($urandom), 0, 1);
         tick(9'($urandom), 1, 1);
         drain(5);
         chk("rnd_xfers", nx, NW);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
